// File: rtl/lsu_core.sv
// Load/store unit: byte-addressable little-endian data memory plus two memory-mapped GPIO words.
// Loads are combinational; stores commit on the rising edge and are sized by a RISC-V style type code.
module lsu_core #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_SPACE  = 4096,
    parameter int NUM_DATA_TYPES = 6,
    parameter logic [$clog2(ADDRESS_SPACE)-1:0] GPIO_A_ADDR = 12'hEF0,
    parameter logic [$clog2(ADDRESS_SPACE)-1:0] GPIO_B_ADDR = 12'hEF4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [$clog2(ADDRESS_SPACE)-1:0]    addr_in,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                WE_in,
    input  logic [$clog2(NUM_DATA_TYPES)-1:0]   dtypes_in,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic [DATA_WIDTH-1:0]               gpioA_out,
    input  logic [DATA_WIDTH-1:0]               gpioB_in
);

    localparam int ADDR_W    = $clog2(ADDRESS_SPACE);
    localparam int DT_W      = $clog2(NUM_DATA_TYPES);
    localparam int NUM_LANES = DATA_WIDTH / 8;

    localparam logic [DT_W-1:0] DT_BYTE   = DT_W'(0);
    localparam logic [DT_W-1:0] DT_HALF   = DT_W'(1);
    localparam logic [DT_W-1:0] DT_WORD   = DT_W'(2);
    localparam logic [DT_W-1:0] DT_BYTE_U = DT_W'(3);
    localparam logic [DT_W-1:0] DT_HALF_U = DT_W'(4);

    logic [7:0]            mem_q [ADDRESS_SPACE];
    logic [DATA_WIDTH-1:0] gpio_a_q, gpio_a_d;

    logic [NUM_LANES-1:0]  lane_sel;
    logic                  dtype_ok;
    logic                  is_gpio_a, is_gpio_b;
    logic                  store_ok, mem_store;
    logic [ADDR_W-1:0]     lane_addr [NUM_LANES];
    logic [7:0]            lane_data [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_we;
    logic [DATA_WIDTH-1:0] rd_word;

    // Decode access size and the write side of the current access.
    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        lane_sel = '0;
        dtype_ok = 1'b1;
        case (dtypes_in)
            DT_BYTE, DT_BYTE_U: lane_sel = NUM_LANES'(1);
            DT_HALF, DT_HALF_U: lane_sel = NUM_LANES'(3);
            DT_WORD:            lane_sel = '1;
            default:            dtype_ok = 1'b0;
        endcase

        is_gpio_a = (addr_in == GPIO_A_ADDR);
        is_gpio_b = (addr_in == GPIO_B_ADDR);
        store_ok  = WE_in && !reset_n && dtype_ok;
        mem_store = store_ok && !is_gpio_a && !is_gpio_b;

        gpio_a_d = gpio_a_q;
        lane_we  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            // Lane addresses wrap naturally at the top of the address space.
            lane_addr[i] = addr_in + ADDR_W'(i);
            lane_data[i] = data_in[8*i +: 8];
            lane_we[i]   = mem_store && lane_sel[i];
            if (store_ok && is_gpio_a && lane_sel[i]) begin
                gpio_a_d[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Read side: gather the byte lanes, then size and extend.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            rd_word[8*i +: 8] = mem_q[lane_addr[i]];
        end
        if (is_gpio_a) begin
            rd_word = gpio_a_q;
        end else if (is_gpio_b) begin
            rd_word = gpioB_in;
        end

        data_out = '0;
        case (dtypes_in)
            DT_BYTE:   data_out = {{(DATA_WIDTH-8){rd_word[7]}}, rd_word[7:0]};
            DT_HALF:   data_out = {{(DATA_WIDTH-16){rd_word[15]}}, rd_word[15:0]};
            DT_WORD:   data_out = rd_word;
            DT_BYTE_U: data_out = {{(DATA_WIDTH-8){1'b0}}, rd_word[7:0]};
            DT_HALF_U: data_out = {{(DATA_WIDTH-16){1'b0}}, rd_word[15:0]};
            default:   data_out = '0;
        endcase
        if (reset_n) begin
            data_out = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            gpio_a_q <= '0;
        end else begin
            gpio_a_q <= gpio_a_d;
        end
    end

    // NOTE: the data memory has no reset; clearing thousands of bytes would defeat RAM inference,
    // and stores are already blocked during reset through lane_we.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_we[i]) begin
                mem_q[lane_addr[i]] <= lane_data[i];
            end
        end
    end

    assign gpioA_out = gpio_a_q;

endmodule

// File: tb/tb_lsu_core.sv
// Self-checking bench for lsu_core: expectations are queued when stimulus is driven and popped on compare.
module tb_lsu_core;

    localparam logic [2:0] DT_B  = 3'd0;
    localparam logic [2:0] DT_H  = 3'd1;
    localparam logic [2:0] DT_W  = 3'd2;
    localparam logic [2:0] DT_BU = 3'd3;
    localparam logic [2:0] DT_HU = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] addr_in;
    logic [31:0] data_in;
    logic        WE_in;
    logic [2:0]  dtypes_in;
    logic [31:0] data_out;
    logic [31:0] gpioA_out;
    logic [31:0] gpioB_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic [11:0] a;
        logic [2:0]  dt;
        logic [31:0] d;
    } acc_t;

    lsu_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .WE_in     (WE_in),
        .dtypes_in (dtypes_in),
        .data_out  (data_out),
        .gpioA_out (gpioA_out),
        .gpioB_in  (gpioB_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Drive one access at the falling edge; a store commits at the following rising edge.
    task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic we, input logic [2:0] dt);
        @(negedge clk);
        addr_in   = a;
        data_in   = d;
        WE_in     = we;
        dtypes_in = dt;
        #1;
    endtask

    task automatic push(input string name, input logic [31:0] exp);
        sb.push_back('{name, exp});
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n   = 1'b1;
        gpioB_in  = 32'hCAFEF00D;
        addr_in   = 12'hEF0;
        data_in   = 32'hFFFFFFFF;
        WE_in     = 1'b1;
        dtypes_in = DT_W;
        repeat (5) @(negedge clk);
        #1;
        push("reset_gpioA", 32'h0);
        e = sb.pop_front(); checks++;
        if (gpioA_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, gpioA_out, e.exp);
        end
        addr_in = 12'hEF4;
        #1;
        push("reset_data_out", 32'h0);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
        WE_in   = 1'b0;
        reset_n = 1'b0;
    endtask

    task automatic test_words();
        exp_t e;
        acc_t st [4];
        acc_t ld [5];
        st = '{'{12'h000, DT_W, 32'hABCDEF00}, '{12'h004, DT_W, 32'h00000010},
               '{12'h008, DT_W, 32'hA0000F12}, '{12'h00C, DT_W, 32'hC0000B00}};
        ld = '{'{12'h000, DT_W, 32'hABCDEF00}, '{12'h004, DT_W, 32'h00000010},
               '{12'h008, DT_W, 32'hA0000F12}, '{12'h00C, DT_W, 32'hC0000B00},
               '{12'h008, DT_B, 32'h00000012}};
        foreach (st[i]) drive(st[i].a, st[i].d, 1'b1, st[i].dt);
        foreach (ld[i]) begin
            drive(ld[i].a, 32'h0, 1'b0, ld[i].dt);
            push($sformatf("word_load_%0d", i), ld[i].d);
            e = sb.pop_front(); checks++;
            if (data_out !== e.exp) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
            end
        end
    endtask

    task automatic test_half();
        exp_t e;
        acc_t ld [4];
        drive(12'h010, 32'h0000ABCD, 1'b1, DT_H);
        drive(12'h012, 32'h0000FFFF, 1'b1, DT_H);
        drive(12'h014, 32'h00001010, 1'b1, DT_H);
        ld = '{'{12'h010, DT_H,  32'hFFFFABCD}, '{12'h010, DT_HU, 32'h0000ABCD},
               '{12'h010, DT_W,  32'hFFFFABCD}, '{12'h014, DT_H,  32'h00001010}};
        foreach (ld[i]) begin
            drive(ld[i].a, 32'h0, 1'b0, ld[i].dt);
            push($sformatf("half_load_%0d", i), ld[i].d);
            e = sb.pop_front(); checks++;
            if (data_out !== e.exp) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
            end
        end
    endtask

    task automatic test_bytes();
        exp_t e;
        acc_t ld [8];
        drive(12'h01A, 32'h000000AB, 1'b1, DT_B);
        drive(12'h01B, 32'h000000CB, 1'b1, DT_BU);
        drive(12'h01C, 32'h000000EF, 1'b1, DT_B);
        drive(12'h01D, 32'h00000011, 1'b1, DT_B);
        ld = '{'{12'h01A, DT_B,  32'hFFFFFFAB}, '{12'h01B, DT_B,  32'hFFFFFFCB},
               '{12'h01C, DT_B,  32'hFFFFFFEF}, '{12'h01D, DT_B,  32'h00000011},
               '{12'h01A, DT_BU, 32'h000000AB}, '{12'h01B, DT_BU, 32'h000000CB},
               '{12'h01C, DT_BU, 32'h000000EF}, '{12'h01D, DT_BU, 32'h00000011}};
        foreach (ld[i]) begin
            drive(ld[i].a, 32'h0, 1'b0, ld[i].dt);
            push($sformatf("byte_load_%0d", i), ld[i].d);
            e = sb.pop_front(); checks++;
            if (data_out !== e.exp) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
            end
        end
    endtask

    task automatic test_load_during_store();
        exp_t e;
        drive(12'h004, 32'h11111111, 1'b1, DT_W);
        push("load_during_store_old", 32'h00000010);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
        drive(12'h004, 32'h0, 1'b0, DT_W);
        push("store_then_load", 32'h11111111);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
    endtask

    task automatic test_gpio();
        exp_t e;
        // Memory right next to the GPIO words, to prove GPIO accesses never reach memory.
        drive(12'hEF1, 32'h0A0B0C0D, 1'b1, DT_W);
        drive(12'hEF5, 32'h01020304, 1'b1, DT_W);
        drive(12'hEF0, 32'h000000AB, 1'b1, DT_W);
        drive(12'hEF0, 32'h0, 1'b0, DT_W);
        push("gpioA_after_store", 32'h000000AB);
        push("gpioA_load", 32'h000000AB);
        e = sb.pop_front(); checks++;
        if (gpioA_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, gpioA_out, e.exp);
        end
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end

        drive(12'hEF4, 32'h000000AB, 1'b1, DT_W);
        gpioB_in = 32'h12345678;
        drive(12'hEF4, 32'h0, 1'b0, DT_W);
        push("gpioB_load", 32'h12345678);
        push("gpioA_held_on_B_store", 32'h000000AB);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
        e = sb.pop_front(); checks++;
        if (gpioA_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, gpioA_out, e.exp);
        end
        drive(12'hEF4, 32'h0, 1'b0, DT_HU);
        push("gpioB_load_hu", 32'h00005678);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end

        // Lane-merged GPIO A writes, then a signed byte read of the register.
        drive(12'hEF0, 32'hFFFF1234, 1'b1, DT_H);
        drive(12'hEF0, 32'hFFFFFF99, 1'b1, DT_BU);
        drive(12'hEF0, 32'h0, 1'b0, DT_B);
        push("gpioA_lane_merge", 32'h00001299);
        push("gpioA_byte_signed", 32'hFFFFFF99);
        e = sb.pop_front(); checks++;
        if (gpioA_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, gpioA_out, e.exp);
        end
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end

        drive(12'hEF1, 32'h0, 1'b0, DT_W);
        push("mem_beside_gpioA", 32'h0A0B0C0D);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
        drive(12'hEF5, 32'h0, 1'b0, DT_W);
        push("mem_beside_gpioB", 32'h01020304);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(12'h000, 32'h55555555, 1'b1, DT_W);
        reset_n = 1'b1;
        #1;
        push("reset_forces_data_out", 32'h0);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
        drive(12'h020, 32'h13579BDF, 1'b1, DT_W);
        push("reset_clears_gpioA", 32'h0);
        e = sb.pop_front(); checks++;
        if (gpioA_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, gpioA_out, e.exp);
        end
        reset_n = 1'b0;
        drive(12'h020, 32'h0, 1'b0, DT_W);
        push("first_store_after_release", 32'h13579BDF);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
        drive(12'h000, 32'h0, 1'b0, DT_W);
        push("store_in_reset_discarded", 32'hABCDEF00);
        e = sb.pop_front(); checks++;
        if (data_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
        end
    endtask

    task automatic test_reserved();
        exp_t e;
        acc_t ld [3];
        drive(12'h000, 32'hFFFFFFFF, 1'b1, 3'd5);
        drive(12'hEF0, 32'hFFFFFFFF, 1'b1, 3'd6);
        ld = '{'{12'h000, DT_W, 32'hABCDEF00}, '{12'h000, 3'd5, 32'h0}, '{12'h008, 3'd7, 32'h0}};
        foreach (ld[i]) begin
            drive(ld[i].a, 32'h0, 1'b0, ld[i].dt);
            push($sformatf("reserved_%0d", i), ld[i].d);
            e = sb.pop_front(); checks++;
            if (data_out !== e.exp) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
            end
        end
        push("reserved_gpioA_held", 32'h0);
        e = sb.pop_front(); checks++;
        if (gpioA_out !== e.exp) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, gpioA_out, e.exp);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        acc_t ld [4];
        drive(12'hFFE, 32'hDEADBEEF, 1'b1, DT_W);
        ld = '{'{12'hFFE, DT_W,  32'hDEADBEEF}, '{12'h000, DT_BU, 32'h000000AD},
               '{12'h001, DT_B,  32'hFFFFFFDE}, '{12'hFFF, DT_HU, 32'h0000ADBE}};
        foreach (ld[i]) begin
            drive(ld[i].a, 32'h0, 1'b0, ld[i].dt);
            push($sformatf("wrap_load_%0d", i), ld[i].d);
            e = sb.pop_front(); checks++;
            if (data_out !== e.exp) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, data_out, e.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_words();
        test_half();
        test_bytes();
        test_load_during_store();
        test_gpio();
        test_reset_mid();
        test_reserved();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
